// File: rtl/float_mul_seq.sv
// Sequential floating-point multiplier front end. It multiplies the significands
// with a shift-add loop and emits an unnormalised sign/exponent/mantissa result.
module float_mul_seq #(
    parameter int  EXP_WIDTH   = 8,
    parameter int  MAN_WIDTH   = 23,
    localparam int FLOAT_WIDTH = EXP_WIDTH + MAN_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] a,
    input  logic [FLOAT_WIDTH-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic [EXP_WIDTH+1:0]   out_exp,
    output logic [MAN_WIDTH+2:0]   out_man,
    output logic                   out_nan
);

    localparam int SIG_W   = MAN_WIDTH + 1;
    localparam int ACC_W   = 2 * MAN_WIDTH + 2;
    localparam int OEXP_W  = EXP_WIDTH + 2;
    localparam int OMAN_W  = MAN_WIDTH + 3;
    localparam int CNT_NAT = $clog2(MAN_WIDTH + 1);
    localparam int CNT_W   = (CNT_NAT > 5) ? CNT_NAT : 5;
    localparam int BIAS    = (1 << (EXP_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // ------------------------------------------------------------------
    // Per-operand decode: index 0 is a, index 1 is b.
    // ------------------------------------------------------------------
    logic [FLOAT_WIDTH-1:0] w_op      [2];
    logic [EXP_WIDTH-1:0]   w_exp_fld [2];
    logic [MAN_WIDTH-1:0]   w_man_fld [2];
    logic [EXP_WIDTH-1:0]   w_exp_eff [2];
    logic [SIG_W-1:0]       w_sig     [2];
    logic [1:0]             w_sign;
    logic [1:0]             w_is_nan;
    logic [1:0]             w_is_inf;
    logic [1:0]             w_is_zero;

    assign w_op[0] = a;
    assign w_op[1] = b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_decode
            logic w_exp_ones;
            logic w_exp_zero;
            logic w_man_zero;

            assign w_sign[gi]    = w_op[gi][FLOAT_WIDTH-1];
            assign w_exp_fld[gi] = w_op[gi][FLOAT_WIDTH-2:MAN_WIDTH];
            assign w_man_fld[gi] = w_op[gi][MAN_WIDTH-1:0];
            assign w_exp_ones    = &w_exp_fld[gi];
            assign w_exp_zero    = ~|w_exp_fld[gi];
            assign w_man_zero    = ~|w_man_fld[gi];
            assign w_is_nan[gi]  = w_exp_ones & ~w_man_zero;
            assign w_is_inf[gi]  = w_exp_ones & w_man_zero;
            assign w_is_zero[gi] = w_exp_zero & w_man_zero;
            // Subnormals share the exponent of the smallest normal, without the hidden one.
            assign w_exp_eff[gi] = w_exp_zero ? EXP_WIDTH'(1) : w_exp_fld[gi];
            assign w_sig[gi]     = {~w_exp_zero, w_man_fld[gi]};
        end
    endgenerate

    logic w_nan;
    logic w_inf;
    logic w_zero;
    logic w_special;
    logic [OEXP_W-1:0] w_exp_sum;

    assign w_nan     = (|w_is_nan) | (w_is_inf[0] & w_is_zero[1]) | (w_is_inf[1] & w_is_zero[0]);
    assign w_inf     = ~w_nan & (|w_is_inf);
    assign w_zero    = ~w_nan & ~w_inf & (|w_is_zero);
    assign w_special = w_nan | w_inf | w_zero;
    assign w_exp_sum = OEXP_W'(w_exp_eff[0]) + OEXP_W'(w_exp_eff[1]) - OEXP_W'(BIAS);

    logic w_accept;
    assign in_ready = (r_state == S_IDLE) && !reset;
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_special ? S_DONE : S_MUL;
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (r_out_valid && out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift-add datapath
    // ------------------------------------------------------------------
    logic [SIG_W-1:0]  r_a_sig;
    logic [SIG_W-1:0]  r_b_sig;
    logic [ACC_W-1:0]  r_acc;
    logic [OEXP_W-1:0] r_exp_sum;
    logic              r_sign;
    logic              r_nan;
    logic              r_inf;
    logic              r_zero;

    logic [SIG_W:0]    w_add;
    logic [ACC_W-1:0]  w_acc_next;

    // The carry out of the add becomes the new MSB after the right shift.
    assign w_add      = {1'b0, r_acc[ACC_W-1:SIG_W]} + (r_b_sig[0] ? {1'b0, r_a_sig} : '0);
    assign w_acc_next = {w_add, r_acc[SIG_W-1:1]};

    logic              r_out_sign;
    logic [OEXP_W-1:0] r_out_exp;
    logic [OMAN_W-1:0] r_out_man;
    logic              r_out_nan;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sig     <= '0;
            r_b_sig     <= '0;
            r_acc       <= '0;
            r_exp_sum   <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_nan       <= 1'b0;
            r_inf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= '0;
            r_out_man   <= '0;
            r_out_nan   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_sig   <= w_sig[0];
                r_b_sig   <= w_sig[1];
                r_acc     <= '0;
                r_exp_sum <= w_exp_sum;
                r_cnt     <= CNT_W'(MAN_WIDTH);
                r_sign    <= w_sign[0] ^ w_sign[1];
                r_nan     <= w_nan;
                r_inf     <= w_inf;
                r_zero    <= w_zero;
            end
            if (r_state == S_MUL) begin
                r_acc   <= w_acc_next;
                r_b_sig <= r_b_sig >> 1;
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
            if (r_state == S_DONE) begin
                if (!r_out_valid) begin
                    // Result is captured once and then held until the handshake.
                    r_out_valid <= 1'b1;
                    r_out_sign  <= r_sign;
                    r_out_nan   <= r_nan;
                    if (r_nan || r_zero) begin
                        r_out_exp <= '0;
                        r_out_man <= '0;
                    end else if (r_inf) begin
                        r_out_exp <= OEXP_W'((1 << EXP_WIDTH) - 1);
                        r_out_man <= {2'b00, 1'b1, {MAN_WIDTH{1'b0}}};
                    end else begin
                        r_out_exp <= r_exp_sum;
                        r_out_man <= {1'b0, r_acc[ACC_W-1:MAN_WIDTH]};
                    end
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sign  = r_out_sign;
    assign out_exp   = r_out_exp;
    assign out_man   = r_out_man;
    assign out_nan   = r_out_nan;

endmodule
